// File: rtl/wb_ctrl_sp_io.sv
// Write-back controller: decodes WB fields into RF writes, owns SP with bound checks, IN port and buffered OUT FIFO.
// Latency: decode/RF write/handshakes are combinational (0 cycles); SP, FIFO and FSM state update on the next rising edge.
// Backpressure: wb_stall holds the pipeline while IN has no data or OUT FIFO is full with no pop; FIFO pops continue while stalled.
module wb_ctrl_sp_io #(
    parameter int                 DATA_W    = 8,
    parameter int                 OUT_DEPTH = 4,
    parameter logic [DATA_W-1:0]  SP_INIT   = 8'hFF,
    parameter logic [DATA_W-1:0]  STACK_LO  = 8'h80,
    parameter logic [DATA_W-1:0]  STACK_HI  = 8'hFF,
    localparam int                LVL_W     = $clog2(OUT_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [3:0]        opcode,
    input  logic [1:0]        ra_wb,
    input  logic [1:0]        rb_wb,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    output logic              rf_we,
    output logic [1:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] sp_q,
    output logic              stk_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  out_level
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    typedef enum logic {RUN = 1'b0, IN_WAIT = 1'b1} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic              fifo_full;
    logic              fifo_push, fifo_pop;
    logic              is_in, is_out;
    logic              sp_dec, sp_inc;

    // Sub-op classification of the WB instruction, used by stall and FSM logic.
    always_comb begin
        is_in  = wb_valid && (opcode == 4'd7) && (ra_wb == 2'd3);
        is_out = wb_valid && (opcode == 4'd7) && (ra_wb == 2'd2);
    end

    assign fifo_full = (out_level == LVL_W'(OUT_DEPTH));
    assign out_valid = (out_level != '0);
    assign out_data  = fifo_mem[rd_ptr_q];
    assign fifo_pop  = out_valid && out_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next state: park in IN_WAIT while an IN waits for data; leave on data or when the instruction goes away.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (is_in && !in_valid)  state_d = IN_WAIT;
            IN_WAIT: if (!is_in || in_valid)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs: stall generation, handshakes, RF write decode and SP/FIFO requests for completing instructions.
    always_comb begin
        wb_stall  = 1'b0;
        in_ready  = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = 2'd0;
        rf_wdata  = '0;
        sp_dec    = 1'b0;
        sp_inc    = 1'b0;
        fifo_push = 1'b0;
        if (wb_valid) begin
            wb_stall = (is_in && !in_valid) || (is_out && fifo_full && !out_ready);
            if (!wb_stall) begin
                case (opcode)
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd10: begin
                        rf_we    = 1'b1;
                        rf_waddr = ra_wb;
                        rf_wdata = wb_data;
                    end
                    4'd6, 4'd12: begin
                        if (ra_wb < 2'd2) begin
                            rf_we    = 1'b1;
                            rf_waddr = rb_wb;
                            rf_wdata = wb_data;
                        end
                    end
                    4'd13: begin
                        rf_we    = 1'b1;
                        rf_waddr = rb_wb;
                        rf_wdata = wb_data;
                    end
                    4'd7: begin
                        case (ra_wb)
                            2'd0: sp_dec = 1'b1;
                            2'd1: begin
                                rf_we    = 1'b1;
                                rf_waddr = rb_wb;
                                rf_wdata = wb_data;
                                sp_inc   = 1'b1;
                            end
                            2'd2: fifo_push = 1'b1;
                            default: begin
                                in_ready = 1'b1;
                                rf_we    = 1'b1;
                                rf_waddr = rb_wb;
                                rf_wdata = in_data;
                            end
                        endcase
                    end
                    4'd11: begin
                        if (ra_wb == 2'd1)      sp_dec = 1'b1;
                        else if (ra_wb != 2'd0) sp_inc = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stack pointer: an RF write to R3 reloads SP and overrides inc/dec; bound hits freeze SP and set the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= SP_INIT;
            stk_err <= 1'b0;
        end else if (rf_we && (rf_waddr == 2'd3)) begin
            sp_q <= rf_wdata;
        end else if (sp_dec) begin
            if (sp_q == STACK_LO) stk_err <= 1'b1;
            else                  sp_q    <= sp_q - DATA_W'(1);
        end else if (sp_inc) begin
            if (sp_q == STACK_HI) stk_err <= 1'b1;
            else                  sp_q    <= sp_q + DATA_W'(1);
        end
    end

    // OUT FIFO pointers and occupancy; push into a full FIFO is only issued together with a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            out_level <= '0;
        end else begin
            if (fifo_push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (fifo_pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   out_level <= out_level + LVL_W'(1);
                2'b01:   out_level <= out_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // OUT FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_q] <= wb_data;
    end

endmodule

// File: tb/tb_wb_ctrl_sp_io.sv
// Directed bench for wb_ctrl_sp_io with hand-computed expectations.
// Inputs are driven 1ns after the rising edge; outputs are sampled 3ns after it.
// Every comparison goes through check(); a summary line closes the run.
module tb_wb_ctrl_sp_io;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid;
    logic [3:0] opcode;
    logic [1:0] ra_wb, rb_wb;
    logic [7:0] wb_data;
    logic       wb_stall, rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata, sp_q;
    logic       stk_err;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] out_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_ctrl_sp_io dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .opcode(opcode),
        .ra_wb(ra_wb), .rb_wb(rb_wb), .wb_data(wb_data), .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sp_q(sp_q),
        .stk_err(stk_err), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_level(out_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] d);
        wb_valid = v;
        opcode   = op;
        ra_wb    = ra;
        rb_wb    = rb;
        wb_data  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'd0, 2'd0, 2'd0, 8'h00);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        do_reset();
        tick();
        settle();

        // Reset state and idle outputs
        check("rst_sp", sp_q, 32'hFF);
        check("rst_err", stk_err, 0);
        check("rst_oval", out_valid, 0);
        check("rst_olvl", out_level, 0);
        check("idle_stall", wb_stall, 0);
        check("idle_we", rf_we, 0);

        // 1: plain ALU write to ra, same cycle
        drive(1'b1, 4'd2, 2'd1, 2'd0, 8'h3C);
        settle();
        check("alu_we", rf_we, 1);
        check("alu_waddr", rf_waddr, 1);
        check("alu_wdata", rf_wdata, 32'h3C);
        check("alu_stall", wb_stall, 0);

        // Decode variants: op6 ra=0 writes rb; op6 ra=2 and op9 do nothing
        drive(1'b1, 4'd6, 2'd0, 2'd2, 8'h11);
        settle();
        check("op6_waddr", {rf_we, rf_waddr}, 32'h6);
        drive(1'b1, 4'd6, 2'd2, 2'd2, 8'h11);
        settle();
        check("op6r2_we", rf_we, 0);
        drive(1'b1, 4'd9, 2'd1, 2'd1, 8'h11);
        settle();
        check("op9_we", rf_we, 0);

        // 2: three PUSHes then POP into R3 (RF load wins over inc)
        drive(1'b1, 4'd7, 2'd0, 2'd0, 8'h00);
        tick(); tick(); tick();
        settle();
        check("push3_sp", sp_q, 32'hFC);
        drive(1'b1, 4'd7, 2'd1, 2'd3, 8'h90);
        settle();
        check("pop_we_addr", {rf_we, rf_waddr}, 32'h7);
        tick();
        settle();
        check("pop_r3_sp", sp_q, 32'h90);

        // 3: CALL at STACK_LO -> SP frozen, sticky error
        drive(1'b1, 4'd2, 2'd3, 2'd0, 8'h80);
        tick();
        settle();
        check("sp_load80", sp_q, 32'h80);
        drive(1'b1, 4'd11, 2'd1, 2'd0, 8'h00);
        tick();
        settle();
        check("call_lo_sp", sp_q, 32'h80);
        check("call_lo_err", stk_err, 1);
        drive(1'b0, 4'd0, 2'd0, 2'd0, 8'h00);
        tick(); tick();
        settle();
        check("err_sticky", stk_err, 1);
        do_reset();
        settle();
        check("err_cleared", stk_err, 0);

        // RET at STACK_HI -> SP frozen at FF, error
        drive(1'b1, 4'd11, 2'd2, 2'd0, 8'h00);
        tick();
        settle();
        check("ret_hi_sp", sp_q, 32'hFF);
        check("ret_hi_err", stk_err, 1);
        do_reset();

        // 4: IN with data arriving after three stalled cycles
        drive(1'b1, 4'd7, 2'd3, 2'd2, 8'h00);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("in_wait_stall", {wb_stall, rf_we, in_ready}, 32'h4);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        settle();
        check("in_done_hs", {wb_stall, rf_we, in_ready}, 32'h3);
        check("in_done_addr", rf_waddr, 2);
        check("in_done_data", rf_wdata, 32'h5A);
        tick();
        in_valid = 1'b0;
        drive(1'b0, 4'd0, 2'd0, 2'd0, 8'h00);
        settle();
        check("in_sp_same", sp_q, 32'hFF);

        // 5: five OUTs into a 4-deep FIFO with the consumer blocked
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'd7, 2'd2, 2'd0, 8'(i));
            settle();
            if (i < 5) begin
                check("out_fill_stall", wb_stall, 0);
                tick();
            end
        end
        check("out_full_stall", wb_stall, 1);
        check("out_full_lvl", out_level, 4);
        tick();
        settle();
        check("out_still_stall", wb_stall, 1);
        check("out_still_lvl", out_level, 4);
        out_ready = 1'b1;
        settle();
        check("out_pp_stall", wb_stall, 0);
        check("out_head1", out_data, 1);
        tick();
        settle();
        check("out_pp_lvl", out_level, 4);
        drive(1'b0, 4'd0, 2'd0, 2'd0, 8'h00);
        for (int k = 2; k <= 5; k++) begin
            settle();
            check("out_order", {out_valid, out_data}, 32'h100 | k);
            tick();
        end
        settle();
        check("out_drained", {out_valid, out_level}, 0);
        out_ready = 1'b0;

        // 6: reset while in IN_WAIT with two buffered OUT entries
        drive(1'b1, 4'd7, 2'd0, 2'd0, 8'h00);
        tick();
        drive(1'b1, 4'd7, 2'd2, 2'd0, 8'hAA);
        tick();
        drive(1'b1, 4'd7, 2'd2, 2'd0, 8'hBB);
        tick();
        drive(1'b1, 4'd7, 2'd3, 2'd1, 8'h00);
        tick();
        settle();
        check("pre_rst_stall", wb_stall, 1);
        check("pre_rst_lvl", out_level, 2);
        check("pre_rst_sp", sp_q, 32'hFE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 2'd0, 2'd0, 8'h00);
        settle();
        check("post_rst_stall", wb_stall, 0);
        check("post_rst_oval", out_valid, 0);
        check("post_rst_lvl", out_level, 0);
        check("post_rst_sp", sp_q, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
